debug_unit: RTL
===============

DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable cycles a synchronized button must hold before its debounced level changes.
REQ-002 clk  input  1  single system clock, rising-edge active.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 succ  input  1  continuous-run switch (level).
REQ-005 step  input  1  single-step button (raw, asynchronous).
REQ-006 sel  input  3  display select switch.
REQ-007 m_rf  input  1  address target: 1 = data memory, 0 = register file.
REQ-008 inc  input  1  address increment button (raw).
REQ-009 dec  input  1  address decrement button (raw).
REQ-010 status  input  16  CPU status word.
REQ-011 m_data  input  32  CPU memory debug read data.
REQ-012 rf_data  input  32  CPU register-file debug read data.
REQ-013 sel_data  input  32  CPU selected internal value for i_sel.
REQ-014 cpu_en  output  1  CPU clock enable; the CPU advances one cycle per clk with cpu_en=1.
REQ-015 m_rf_addr  output  16  debug read address to the CPU.
REQ-016 i_sel  output  3  internal-value select to the CPU.
REQ-017 led  output  16  LED bank.
REQ-018 disp_data  output  32  seven-segment display value.

Function
REQ-019 The block SHALL pass each of step, inc and dec through a 2-flop synchronizer, a debounce counter and a rising-edge detector, yielding one 1-cycle pulse per accepted press.
REQ-020 The debounced level SHALL change only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any mismatch gap SHALL restart the count.
REQ-021 The step pulse SHALL occur exactly DB_CYCLES+3 cycles after the raw rising edge; inc and dec SHALL have the same latency.
REQ-022 A held button SHALL produce one pulse only; its release SHALL produce no pulse.
REQ-023 cpu_en SHALL be a register: 1 every cycle while succ=1; otherwise 1 for exactly the cycle after a step pulse, else 0.
REQ-024 A step pulse while succ=1 SHALL have no additional effect.
REQ-025 m_rf_addr SHALL increment by 1 on an inc pulse and decrement by 1 on a dec pulse, wrapping modulo 2^16 (0xFFFF+1 = 0x0000, 0x0000-1 = 0xFFFF).
REQ-026 Coincident inc and dec pulses SHALL leave m_rf_addr unchanged.
REQ-027 i_sel SHALL be sel registered once (1-cycle latency).
REQ-028 When i_sel=0, disp_data SHALL be m_data if m_rf=1, otherwise rf_data; when i_sel!=0, disp_data SHALL be sel_data; registered, 1-cycle latency.
REQ-029 When i_sel=0, led SHALL be m_rf_addr; otherwise led SHALL be status; registered, 1-cycle latency.

Reset
REQ-030 While rst=1, cpu_en=0, m_rf_addr=0, i_sel=0, led=0 and disp_data=0, and all synchronizer, debounce-counter and edge-detect state SHALL be 0.
REQ-031 rst asserted mid-debounce SHALL discard the pending press; no pulse SHALL result from it after release of rst unless the button is still held long enough to be re-qualified.
REQ-032 cpu_en SHALL be 0 on the first clk after rst deasserts, regardless of succ.

Structure
REQ-033 The DB_CYCLES default and the sel encoding (0 = memory/regfile view, 1-7 = CPU internal values) SHALL live in the shared project header, included by this block and by the CPU.
REQ-034 The per-button chain SHALL be one sub-module, btn_pulse, instantiated three times (step, inc, dec).

Verification
REQ-035 With succ=0, hold step high for 20 cycles -> exactly one cpu_en=1 cycle, at DB_CYCLES+4 cycles after the press.
REQ-036 Step glitch high for DB_CYCLES-1 cycles, then low -> no cpu_en pulse.
REQ-037 Set m_rf_addr=0 and press dec once -> m_rf_addr=0xFFFF; then press inc twice -> 0x0001.
REQ-038 inc and dec pressed on the same cycle -> m_rf_addr unchanged.
REQ-039 Drive sel=0, m_rf=1, m_data=0xDEADBEEF and m_rf_addr=5 -> disp_data=0xDEADBEEF and led=0x0005 on the next cycle; then drive sel=3, sel_data=0x12345678 and status=0xA5A5 -> i_sel=3, disp_data=0x12345678 and led=0xA5A5 on the next cycle.
REQ-040 succ=1 -> cpu_en=1 every cycle; assert rst mid-run -> all outputs 0 immediately, and cpu_en=0 on the first cycle after release.

Source files
------------

// File: rtl/debug_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debug_unit_pkg
//  Description : Shared project header for the debug unit and the CPU:
//                debounce default, display-select encoding, pulse bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package debug_unit_pkg;

  // Default number of stable cycles a button must hold before it is accepted.
  localparam int DB_CYCLES_DEFAULT = 4;

  // Display select: 0 shows the memory/register-file view, 1-7 pick a CPU
  // internal value that the CPU returns on sel_data.
  typedef enum logic [2:0] {
    SEL_MEM_RF = 3'd0,
    SEL_INT1   = 3'd1,
    SEL_INT2   = 3'd2,
    SEL_INT3   = 3'd3,
    SEL_INT4   = 3'd4,
    SEL_INT5   = 3'd5,
    SEL_INT6   = 3'd6,
    SEL_INT7   = 3'd7
  } sel_t;

  // One-cycle press pulses of the three buttons.
  typedef struct packed {
    logic step;
    logic inc;
    logic dec;
  } btn_pulses_t;

  // True when the select value picks the memory/register-file view.
  function automatic logic view_is_memrf(input logic [2:0] s);
    return (sel_t'(s) == SEL_MEM_RF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : debug_unit_if
//  Description : Panel and CPU debug bus of the debug unit. The slave modport
//                is the debug unit's view, the master modport the
//                environment's (panel switches/buttons plus the CPU).
//  Revision    : 1.0 - initial release
// ============================================================================
interface debug_unit_if;
  logic        succ;
  logic        step;
  logic [2:0]  sel;
  logic        m_rf;
  logic        inc;
  logic        dec;
  logic [15:0] status;
  logic [31:0] m_data;
  logic [31:0] rf_data;
  logic [31:0] sel_data;
  logic        cpu_en;
  logic [15:0] m_rf_addr;
  logic [2:0]  i_sel;
  logic [15:0] led;
  logic [31:0] disp_data;

  modport slave (
    input  succ, step, sel, m_rf, inc, dec, status, m_data, rf_data, sel_data,
    output cpu_en, m_rf_addr, i_sel, led, disp_data
  );

  modport master (
    output succ, step, sel, m_rf, inc, dec, status, m_data, rf_data, sel_data,
    input  cpu_en, m_rf_addr, i_sel, led, disp_data
  );
endinterface
`default_nettype wire

// File: rtl/btn_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pulse
//  Description : Raw push-button to single-cycle press pulse: 2-flop
//                synchronizer, debounce counter, registered rising-edge
//                detector. Latency from raw edge to pulse is DB_CYCLES+3.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_pulse
  import debug_unit_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_raw,
  output logic      o_pulse
);

  // Counter only needs to reach DB_CYCLES-1; the DB_CYCLES-th mismatch flips.
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_prev;
  logic             r_pulse;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], i_raw};
  end

  // Accept a new level only after DB_CYCLES consecutive mismatching samples;
  // any agreeing sample in between restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync[1] != r_level) begin
      if (r_cnt == c_CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Registered rising edge of the debounced level: one pulse per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= r_level;
      r_pulse <= r_level & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/debug_unit.sv
`default_nettype none
// ============================================================================
//  Module      : debug_unit
//  Description : Front-panel debug controller for the CPU: run/single-step
//                clock enable, debug read address stepping, and the LED /
//                seven-segment display multiplexers.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  wire logic    clk,
  input  wire logic    rst,
  debug_unit_if.slave  bus
);

  logic [2:0]  w_raw;
  logic [2:0]  w_pulse;
  btn_pulses_t w_pulses;
  logic        w_memrf_view;

  logic        r_started;
  logic        r_cpu_en;
  logic [15:0] r_addr;
  logic [2:0]  r_i_sel;
  logic [15:0] r_led;
  logic [31:0] r_disp;

  // Bit order matches btn_pulses_t: step is the MSB.
  assign w_raw    = {bus.step, bus.inc, bus.dec};
  assign w_pulses = w_pulse;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      btn_pulse #(
        .DB_CYCLES (DB_CYCLES)
      ) u_btn_pulse (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (w_raw[gi]),
        .o_pulse (w_pulse[gi])
      );
    end
  endgenerate

  // Run while succ is high, otherwise one enable cycle per step press. The
  // first edge after reset is held off so the CPU never runs on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_started <= 1'b0;
      r_cpu_en  <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_cpu_en  <= r_started & (bus.succ | w_pulses.step);
    end
  end

  // Debug address stepping; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= 16'h0000;
    end else begin
      case ({w_pulses.inc, w_pulses.dec})
        2'b10:   r_addr <= r_addr + 16'h0001;
        2'b01:   r_addr <= r_addr - 16'h0001;
        default: r_addr <= r_addr;
      endcase
    end
  end

  // The display path decodes the incoming select so that i_sel, led and
  // disp_data all switch together on the same edge.
  assign w_memrf_view = view_is_memrf(bus.sel);

  // Register the select and the LED / seven-segment views.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_sel <= 3'd0;
      r_led   <= 16'h0000;
      r_disp  <= 32'h0000_0000;
    end else begin
      r_i_sel <= bus.sel;
      r_led   <= w_memrf_view ? r_addr : bus.status;
      r_disp  <= w_memrf_view ? (bus.m_rf ? bus.m_data : bus.rf_data)
                              : bus.sel_data;
    end
  end

  assign bus.cpu_en    = r_cpu_en;
  assign bus.m_rf_addr = r_addr;
  assign bus.i_sel     = r_i_sel;
  assign bus.led       = r_led;
  assign bus.disp_data = r_disp;

endmodule
`default_nettype wire
